apb_multi_slave_master: RTL and testbench

Synthesisable APB4 requester that accepts simple valid/ready read/write commands, buffers them in a small FIFO, and issues them on an APB bus shared by up to 16 slaves. Address decode, wait-state timeout and per-transfer error reporting are built in. It is the RTL counterpart of the APB master agent and is the bus-driving front end in the SPI-master subsystem test harness. Compared with the single-slave, fixed-width master it adds parametrised width, depth and slave count, decode errors, timeout, and response back-pressure.

---
 rtl/apb_master_global_pkg.sv | 21 ++
 rtl/apb_req_fifo.sv | 49 ++++
 rtl/apb_multi_slave_master.sv | 171 +++++++++++++++++
 tb/tb_apb_multi_slave_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_global_pkg.sv
// Shared types and default widths for the APB requester.
package apb_master_global_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int NO_OF_SLAVES     = 1;
  localparam int LOG_BUFFER_DEPTH = 1;
  localparam int STRB_WIDTH       = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_requester_state_e;

  // Sized at the maximum widths; narrower instances zero-extend into it.
  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [STRB_WIDTH-1:0]    strb;
    logic [2:0]               prot;
  } apb_req_s;

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rd_cmd.
module apb_req_fifo import apb_master_global_pkg::*; #(
  parameter int LOG_DEPTH = LOG_BUFFER_DEPTH
)(
  input  logic               pclk,
  input  logic               preset,
  input  logic               push,
  input  logic               pop,
  input  apb_req_s           wr_cmd,
  output apb_req_s           rd_cmd,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);
  localparam int DEPTH = 2 ** LOG_DEPTH;

  apb_req_s             mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic                 do_push, do_pop;

  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;   // no bypass: full refuses even while popping
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB4 requester: buffered valid/ready commands out to up to 16 slaves,
// with address decode, wait-state timeout and per-transfer error report.
module apb_multi_slave_master #(
  parameter int NO_OF_SLAVES      = apb_master_global_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH     = apb_master_global_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH        = apb_master_global_pkg::DATA_WIDTH,
  parameter int LOG_BUFFER_DEPTH  = apb_master_global_pkg::LOG_BUFFER_DEPTH,
  parameter int SLAVE_REGION_BITS = 12,
  parameter int TIMEOUT_CYCLES    = 16
)(
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDRESS_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [DATA_WIDTH/8-1:0]            req_strb,
  input  logic [2:0]                         req_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_slverr,
  output logic                               rsp_decerr,
  output logic                               rsp_timeout,
  output logic [LOG_BUFFER_DEPTH:0]          fifo_count,
  output logic [NO_OF_SLAVES-1:0]            psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDRESS_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [2:0]                         pprot,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr
);
  import apb_master_global_pkg::*;

  localparam int SW = DATA_WIDTH / 8;

  apb_requester_state_e    state, state_n;
  apb_req_s                push_cmd, head;
  logic                    full, empty, pop, to_hit;
  logic [3:0]              head_idx;
  logic                    head_upper_zero;
  logic [NO_OF_SLAVES-1:0] head_oh, sel_oh;
  logic [31:0]             wait_cnt;
  logic                    bus_done, bus_err;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  assign push_cmd = '{write: req_write, addr: 32'(req_addr), wdata: 32'(req_wdata),
                      strb: 4'(req_strb), prot: req_prot};

  apb_req_fifo #(.LOG_DEPTH(LOG_BUFFER_DEPTH)) u_fifo (
    .pclk   (pclk),
    .preset (preset),
    .push   (req_valid),
    .pop    (pop),
    .wr_cmd (push_cmd),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign req_ready = !full;

  // An index at or above NO_OF_SLAVES shifts the one-hot out to zero, so an
  // all-zero select doubles as the decode-error marker.
  assign head_idx        = head.addr[SLAVE_REGION_BITS +: 4];
  assign head_upper_zero = ((head.addr >> (SLAVE_REGION_BITS + 4)) == 32'd0);
  assign head_oh         = head_upper_zero ? (NO_OF_SLAVES'(1) << head_idx) : '0;

  assign psel      = (state == SETUP || state == ACCESS) ? sel_oh : '0;
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  // Mux the selected slave's response signals.
  always_comb begin
    bus_done  = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_oh[i]) begin
        bus_done  = bus_done | pready[i];
        bus_err   = bus_err | pslverr[i];
        bus_rdata = bus_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and FIFO pop. A decode error still spends the SETUP slot
  // (with no psel), giving a fixed two-cycle accept-to-response latency.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE:   if (!empty) begin pop = 1'b1; state_n = SETUP; end
      SETUP:  state_n = (|sel_oh) ? ACCESS : RESP;
      ACCESS: begin
        if (bus_done) state_n = RESP;
        else if (TIMEOUT_CYCLES != 0 && wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          to_hit  = 1'b1;
          state_n = RESP;
        end
      end
      RESP:   if (rsp_ready) begin
        if (!empty) begin pop = 1'b1; state_n = SETUP; end
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_n;
  end

  // Bus fields load on pop; response fields settle at the end of the transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      sel_oh      <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_decerr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (pop) begin
      paddr       <= head.addr[ADDRESS_WIDTH-1:0];
      pwrite      <= head.write;
      pwdata      <= head.write ? head.wdata[DATA_WIDTH-1:0] : '0;
      pstrb       <= head.write ? head.strb[SW-1:0] : '0;
      pprot       <= head.prot;
      sel_oh      <= head_oh;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_decerr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        SETUP: if (!(|sel_oh)) begin
          rsp_decerr <= 1'b1;
          rsp_slverr <= 1'b1;
        end
        ACCESS: begin
          if (bus_done) begin
            rsp_slverr <= bus_err;
            rsp_rdata  <= (pwrite || bus_err) ? '0 : bus_rdata;
          end else if (to_hit) begin
            rsp_timeout <= 1'b1;
            rsp_slverr  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Scoreboard bench: commands push expected bus transfers and responses;
// a slave BFM and a response monitor pop and compare independently.
module tb_apb_multi_slave_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_decerr, rsp_timeout;
  logic [1:0]  fifo_count;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [63:0] prdata;
  logic [1:0]  pready, pslverr;

  apb_multi_slave_master #(
    .NO_OF_SLAVES(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .LOG_BUFFER_DEPTH(1), .SLAVE_REGION_BITS(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_decerr(rsp_decerr), .rsp_timeout(rsp_timeout),
    .fifo_count(fifo_count), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    bit          slverr, decerr, tmo;
    int          lat, acc;
  } rsp_t;

  typedef struct {
    logic [1:0]  sel;
    int          idx;
    logic [31:0] addr, wdata, rdata;
    bit          write, err;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
  } bus_t;

  rsp_t exp_rsp[$];
  bus_t bq[$];
  int   n_cmp = 0, n_mis = 0;
  int   cyc = 0;
  int   rr_mode = 0;   // 0: rsp_ready=1, 1: random, 2: rsp_ready=0

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Issue one command and record what the bus and response must look like.
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int waits,
                      input bit err, input logic [31:0] rd, input int lat);
    bit   ok = 0;
    bit   dec;
    int   idx;
    rsp_t r;
    bus_t b;
    @(posedge pclk); #1;
    req_write = w; req_addr = a; req_wdata = wd; req_strb = st; req_prot = pr;
    req_valid = 1'b1;
    idx = int'(a[15:12]);
    dec = (a[31:16] == 16'h0) && (idx < 2);
    if (!dec)            r = '{32'h0, 1'b1, 1'b1, 1'b0, lat, 0};
    else if (waits >= 16) r = '{32'h0, 1'b1, 1'b0, 1'b1, lat, 0};
    else if (err)        r = '{32'h0, 1'b1, 1'b0, 1'b0, lat, 0};
    else                 r = '{w ? 32'h0 : rd, 1'b0, 1'b0, 1'b0, lat, 0};
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge pclk);
      if (req_ready) begin
        ok = 1;
        r.acc = cyc + 1;
        exp_rsp.push_back(r);
        if (dec) begin
          b.sel = 2'b01 << idx; b.idx = idx; b.addr = a;
          b.write = w; b.wdata = w ? wd : 32'h0; b.strb = w ? st : 4'h0;
          b.prot = pr; b.waits = waits; b.err = err; b.rdata = rd;
          bq.push_back(b);
        end
      end
    end
    if (!ok) fail_now("req_accept_timeout");
    @(posedge pclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge pclk);
      if (exp_rsp.size() == 0 && bq.size() == 0 && !rsp_valid && psel == 2'b00) done = 1;
    end
    if (!done) fail_now("idle_timeout");
    repeat (2) @(posedge pclk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'h0);
    chk({tag, "_penable"}, 32'(penable), 32'h0);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'h0);
    chk({tag, "_paddr"}, paddr, 32'h0);
    chk({tag, "_pwdata"}, pwdata, 32'h0);
    chk({tag, "_pstrb"}, 32'(pstrb), 32'h0);
    chk({tag, "_pprot"}, 32'(pprot), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_slverr"}, 32'(rsp_slverr), 32'h0);
    chk({tag, "_rsp_decerr"}, 32'(rsp_decerr), 32'h0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'h0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
  endtask

  // rsp_ready driver.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge pclk); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Slave BFM: checks each SETUP against the expected transfer and plays the
  // chosen wait states; unselected lanes carry noise.
  initial begin
    bus_t b;
    bit   in_x = 0;
    int   waits_left = 0, acc_n = 0;
    pready = '0; pslverr = '0; prdata = '0;
    forever begin
      @(negedge pclk);
      pready  = 2'($urandom);
      pslverr = 2'($urandom);
      prdata  = {$urandom, $urandom};
      if (preset) begin
        in_x = 0;
      end else if (psel != 2'b00 && !penable) begin
        if (bq.size() == 0) fail_now("psel_unexpected");
        else begin
          b = bq.pop_front();
          chk("setup_psel", 32'(psel), 32'(b.sel));
          chk("setup_paddr", paddr, b.addr);
          chk("setup_pwrite", 32'(pwrite), 32'(b.write));
          chk("setup_pwdata", pwdata, b.wdata);
          chk("setup_pstrb", 32'(pstrb), 32'(b.strb));
          chk("setup_pprot", 32'(pprot), 32'(b.prot));
          in_x = 1; acc_n = 0; waits_left = b.waits;
        end
      end else if (psel != 2'b00 && penable) begin
        if (!in_x) fail_now("penable_without_setup");
        else begin
          acc_n++;
          chk("access_psel", 32'(psel), 32'(b.sel));
          if (waits_left == 0) begin
            pready[b.idx]  = 1'b1;
            pslverr[b.idx] = b.err;
            prdata[b.idx*32 +: 32] = b.rdata;
          end else begin
            pready[b.idx] = 1'b0;
            waits_left--;
          end
        end
      end else if (in_x) begin
        in_x = 0;
        chk("penable_cycles", 32'(acc_n), 32'(b.waits >= 16 ? 16 : b.waits + 1));
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    bit   seen = 0;
    forever begin
      @(negedge pclk);
      if (preset) seen = 0;
      else if (rsp_valid) begin
        if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = exp_rsp[0];
          if (!seen) begin
            seen = 1;
            if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          if (rsp_ready) begin
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
            chk("rsp_decerr", 32'(rsp_decerr), 32'(e.decerr));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            void'(exp_rsp.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r, wt;
    bit          hit;
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_reset("reset");
    preset = 1'b0;
    repeat (2) @(posedge pclk);

    // Zero-wait write to slave 1.
    send(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 0, 32'h0, 3);
    wait_idle();
    // Read from slave 0 with four wait states.
    send(0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hA, 3'b001, 4, 0, 32'h1234_5678, 7);
    wait_idle();
    // Decode errors: index out of range, then nonzero upper address bits.
    send(0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 0, 0, 32'h0, 2);
    wait_idle();
    send(1, 32'h0001_0004, 32'h5555_AAAA, 4'h3, 3'b100, 0, 0, 32'h0, 2);
    wait_idle();
    // Timeout boundary: 15 low cycles completes, 16 aborts.
    send(0, 32'h0000_1020, 32'h0, 4'h0, 3'b000, 15, 0, 32'hCAFE_F00D, 18);
    wait_idle();
    send(0, 32'h0000_0030, 32'h0, 4'h0, 3'b000, 1000, 0, 32'hBAD0_BAD0, 18);
    wait_idle();
    // Slave error on a read forces rdata to zero.
    send(0, 32'h0000_1040, 32'h0, 4'h0, 3'b011, 2, 1, 32'h7777_7777, 5);
    wait_idle();

    // Back-pressure: three accepted (one in flight, two buffered), fourth waits.
    rr_mode = 2;
    repeat (2) @(posedge pclk);
    send(1, 32'h0000_0100, 32'h1111_1111, 4'h1, 3'b000, 0, 0, 32'h0, -1);
    send(0, 32'h0000_1104, 32'h0, 4'h0, 3'b001, 1, 0, 32'h2222_2222, -1);
    send(0, 32'h0000_0108, 32'h0, 4'h0, 3'b010, 0, 0, 32'h3333_3333, -1);
    repeat (4) @(negedge pclk);
    chk("full_req_ready", 32'(req_ready), 32'h0);
    chk("full_fifo_count", 32'(fifo_count), 32'h2);
    fork
      send(1, 32'h0000_110C, 32'h4444_4444, 4'hC, 3'b111, 0, 0, 32'h0, -1);
      begin repeat (3) @(posedge pclk); #1; rr_mode = 0; end
    join
    wait_idle();

    // Reset during ACCESS drops the transfer and its response.
    send(0, 32'h0000_1010, 32'h0, 4'h0, 3'b000, 10, 0, 32'h9999_0000, -1);
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge pclk);
      if (penable) hit = 1;
    end
    if (!hit) fail_now("access_not_reached");
    preset = 1'b1;
    @(posedge pclk);
    exp_rsp.delete();
    bq.delete();
    @(negedge pclk);
    check_reset("midreset");
    preset = 1'b0;
    repeat (10) @(posedge pclk);

    // Randomized traffic with random back-pressure.
    rr_mode = 1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = {16'h0, 4'($urandom_range(0, 1)), 12'($urandom)};
      else if (r < 9) a = {16'h0, 4'($urandom_range(2, 15)), 12'($urandom)};
      else            a = {16'($urandom_range(1, 65535)), 16'($urandom)};
      r = $urandom_range(0, 9);
      if (r < 6)      wt = $urandom_range(0, 3);
      else if (r < 8) wt = $urandom_range(4, 15);
      else            wt = $urandom_range(16, 30);
      send(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), wt,
           ($urandom_range(0, 4) == 0), $urandom, -1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge pclk);
    end
    rr_mode = 0;
    wait_idle();
    chk("leftover_rsp", 32'(exp_rsp.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
